// File: rtl/oddeven_pkg.sv
// Shared types and constants for the odd/even stream classifier.
package oddeven_pkg;

  typedef enum logic {
    MODE_LSB    = 1'b0,
    MODE_PARITY = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic ODD  = 1'b1;
  localparam logic EVEN = 1'b0;

endpackage

// File: rtl/oddeven_classify.sv
// Combinational odd/even decision: numeric LSB or XOR-parity of the sample.
module oddeven_classify
  import oddeven_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  mode_e            mode,
  output logic             is_odd
);

  always_comb begin
    is_odd = EVEN;
    case (mode)
      MODE_LSB:    is_odd = data[0];
      MODE_PARITY: is_odd = ^data;
      default:     is_odd = EVEN;
    endcase
  end

endmodule

// File: rtl/oddeven_stream.sv
// Streaming odd/even classifier with a one-entry result register and
// saturating per-class counters.
module oddeven_stream
  import oddeven_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] odd_cnt,
  output logic [CNT_W-1:0] even_cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic             vld_q;
  logic [OUT_W-1:0] data_q;
  logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;
  logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
  logic             sat_q, sat_d;

  logic             is_odd;
  logic             accept;
  mode_e            mode_s;

  assign mode_s   = mode_e'(mode);
  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  oddeven_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .data   (in_data),
    .mode   (mode_s),
    .is_odd (is_odd)
  );

  // Holding register: a simultaneous drain and accept stays FULL with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_FULL;
            vld_q   <= 1'b1;
            data_q  <= OUT_W'(is_odd);
          end
        end
        ST_FULL: begin
          if (accept) begin
            data_q <= OUT_W'(is_odd);
          end else if (out_ready) begin
            state_q <= ST_EMPTY;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // Clear zeroes the base first so a same-cycle accept lands on 1.
  always_comb begin
    odd_cnt_d  = clear ? '0 : odd_cnt_q;
    even_cnt_d = clear ? '0 : even_cnt_q;
    sat_d      = clear ? 1'b0 : sat_q;
    if (accept) begin
      if (is_odd == ODD) begin
        if (odd_cnt_d == CNT_MAX) sat_d = 1'b1;
        else                      odd_cnt_d = odd_cnt_d + CNT_W'(1);
      end else begin
        if (even_cnt_d == CNT_MAX) sat_d = 1'b1;
        else                       even_cnt_d = even_cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_cnt_q  <= '0;
      even_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      odd_cnt_q  <= odd_cnt_d;
      even_cnt_q <= even_cnt_d;
      sat_q      <= sat_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign odd_cnt   = odd_cnt_q;
  assign even_cnt  = even_cnt_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_oddeven_stream.sv
// Bench: three configurations share one stimulus stream and are checked
// against an arithmetic model every cycle, plus directed literal checks.
module tb_oddeven_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] din = '0;

  logic       rdy0, rdy1, rdy2, vld0, vld1, vld2, sat0, sat1, sat2;
  logic [3:0] od0, od1, od2;
  logic [7:0] oc0, ec0, oc2, ec2;
  logic [1:0] oc1, ec1;

  oddeven_stream #(.WIDTH(4), .OUT_W(4), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(din[3:0]), .mode(mode), .clear(clear), .out_valid(vld0),
    .out_ready(out_ready), .out_data(od0), .odd_cnt(oc0), .even_cnt(ec0), .sat(sat0));

  oddeven_stream #(.WIDTH(4), .OUT_W(4), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(din[3:0]), .mode(mode), .clear(clear), .out_valid(vld1),
    .out_ready(out_ready), .out_data(od1), .odd_cnt(oc1), .even_cnt(ec1), .sat(sat1));

  oddeven_stream #(.WIDTH(16), .OUT_W(4), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(din), .mode(mode), .clear(clear), .out_valid(vld2),
    .out_ready(out_ready), .out_data(od2), .odd_cnt(oc2), .even_cnt(ec2), .sat(sat2));

  logic [2:0] rdy_w, vld_w, sat_w;
  logic [3:0] od_w [3];
  logic [7:0] oc_w [3];
  logic [7:0] ec_w [3];
  assign rdy_w = {rdy2, rdy1, rdy0};
  assign vld_w = {vld2, vld1, vld0};
  assign sat_w = {sat2, sat1, sat0};
  assign od_w[0] = od0;
  assign od_w[1] = od1;
  assign od_w[2] = od2;
  assign oc_w[0] = oc0;
  assign oc_w[1] = {6'd0, oc1};
  assign oc_w[2] = oc2;
  assign ec_w[0] = ec0;
  assign ec_w[1] = {6'd0, ec1};
  assign ec_w[2] = ec2;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int wof(input int k);
    return (k == 2) ? 16 : 4;
  endfunction

  function automatic int maxof(input int k);
    return (k == 1) ? 3 : 255;
  endfunction

  function automatic int cls(input int k, input logic [15:0] x, input logic m);
    int v;
    v = int'(x) & ((1 << wof(k)) - 1);
    return m ? ($countones(v) % 2) : (v % 2);
  endfunction

  function automatic int sinc(input int base, input int mx);
    return (base >= mx) ? mx : base + 1;
  endfunction

  bit m_full [3] = '{0, 0, 0};
  int m_data [3] = '{0, 0, 0};
  int m_odd  [3] = '{0, 0, 0};
  int m_even [3] = '{0, 0, 0};
  bit m_sat  [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_full[k] <= 0; m_data[k] <= 0; m_odd[k] <= 0; m_even[k] <= 0; m_sat[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (in_valid && (!m_full[k] || out_ready)) begin
          m_full[k] <= 1;
          m_data[k] <= cls(k, din, mode);
          if (cls(k, din, mode) == 1) begin
            m_odd[k]  <= sinc(clear ? 0 : m_odd[k], maxof(k));
            m_even[k] <= clear ? 0 : m_even[k];
            m_sat[k]  <= (clear ? 1'b0 : m_sat[k]) | (!clear && m_odd[k] == maxof(k));
          end else begin
            m_even[k] <= sinc(clear ? 0 : m_even[k], maxof(k));
            m_odd[k]  <= clear ? 0 : m_odd[k];
            m_sat[k]  <= (clear ? 1'b0 : m_sat[k]) | (!clear && m_even[k] == maxof(k));
          end
        end else begin
          if (out_ready) m_full[k] <= 0;
          if (clear) begin
            m_odd[k] <= 0; m_even[k] <= 0; m_sat[k] <= 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.out_valid", k), 32'(vld_w[k]), 32'(m_full[k]));
      chk($sformatf("u%0d.out_data", k),  32'(od_w[k]),  m_data[k]);
      chk($sformatf("u%0d.in_ready", k),  32'(rdy_w[k]), 32'(!m_full[k] || out_ready));
      chk($sformatf("u%0d.odd_cnt", k),   32'(oc_w[k]),  m_odd[k]);
      chk($sformatf("u%0d.even_cnt", k),  32'(ec_w[k]),  m_even[k]);
      chk($sformatf("u%0d.sat", k),       32'(sat_w[k]), 32'(m_sat[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [15:0] d, input logic m,
                       input logic c, input logic r);
    in_valid = v; din = d; mode = m; clear = c; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_all(input string tag);
    chk({tag, " u0.out_valid"}, 32'(vld0), 0);
    chk({tag, " u0.out_data"},  32'(od0), 0);
    chk({tag, " u0.odd_cnt"},   32'(oc0), 0);
    chk({tag, " u0.even_cnt"},  32'(ec0), 0);
    chk({tag, " u0.sat"},       32'(sat0), 0);
    chk({tag, " u0.in_ready"},  32'(rdy0), 1);
    chk({tag, " u1.out_valid"}, 32'(vld1), 0);
    chk({tag, " u2.out_valid"}, 32'(vld2), 0);
    chk({tag, " u2.in_ready"},  32'(rdy2), 1);
  endtask

  logic [7:0] oc_hold;
  logic [15:0] tdat [4];
  logic        tmod [4];
  logic [3:0]  texp [4];

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_reset_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LSB sweep 0..F back-to-back
    for (int i = 0; i < 16; i++) begin
      drive(1, 16'(i), 0, 0, 1);
      chk("sweep u0.out_data", 32'(od0), i & 1);
      chk("sweep u0.in_ready", 32'(rdy0), 1);
    end
    chk("sweep u0.odd_cnt", 32'(oc0), 8);
    chk("sweep u0.even_cnt", 32'(ec0), 8);
    chk("sweep u1.odd_cnt sat", 32'(oc1), 3);
    chk("sweep u1.sat", 32'(sat1), 1);

    // parity 3,7,0,E
    tdat[0] = 16'h3; tdat[1] = 16'h7; tdat[2] = 16'h0; tdat[3] = 16'hE;
    texp[0] = 4'h0;  texp[1] = 4'h1;  texp[2] = 4'h0;  texp[3] = 4'h1;
    for (int i = 0; i < 4; i++) begin
      drive(1, tdat[i], 1, 0, 1);
      chk("parity u0.out_data", 32'(od0), 32'(texp[i]));
    end
    drive(0, 0, 0, 1, 1);

    // backpressure hold
    drive(1, 16'h5, 0, 0, 0);
    chk("stall u0.out_valid", 32'(vld0), 1);
    chk("stall u0.out_data", 32'(od0), 1);
    chk("stall u0.in_ready", 32'(rdy0), 0);
    oc_hold = oc0;
    chk("stall u0.odd_cnt first", 32'(oc_hold), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h9, 0, 0, 0);
      chk("stall u0.out_data held", 32'(od0), 1);
      chk("stall u0.out_valid held", 32'(vld0), 1);
      chk("stall u0.odd_cnt held", 32'(oc0), 32'(oc_hold));
    end
    drive(0, 0, 0, 0, 1);
    chk("drain u0.out_valid", 32'(vld0), 0);

    // CNT_W=2 saturation then clear+accept
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 16'h1, 0, 0, 1);
    chk("satur u1.odd_cnt", 32'(oc1), 3);
    chk("satur u1.sat", 32'(sat1), 1);
    drive(1, 16'h2, 0, 1, 1);
    chk("clracc u1.odd_cnt", 32'(oc1), 0);
    chk("clracc u1.even_cnt", 32'(ec1), 1);
    chk("clracc u1.sat", 32'(sat1), 0);
    chk("clracc u1.out_data", 32'(od1), 0);

    // reset mid-transfer
    drive(1, 16'h3, 0, 0, 0);
    chk("pre-rst u0.out_valid", 32'(vld0), 1);
    rst_n = 1'b0;
    #1 chk_reset_all("midrst");
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    chk("postrst u0.out_valid", 32'(vld0), 0);
    drive(0, 0, 0, 0, 1);
    chk("postrst u2.out_valid", 32'(vld2), 0);

    // WIDTH=16 parity and per-sample mode toggles
    tdat[0] = 16'h8001; tmod[0] = 1; texp[0] = 4'h0;
    tdat[1] = 16'h8000; tmod[1] = 1; texp[1] = 4'h1;
    tdat[2] = 16'h8001; tmod[2] = 0; texp[2] = 4'h1;
    tdat[3] = 16'h8000; tmod[3] = 0; texp[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1, tdat[i], tmod[i], 0, 1);
      chk("w16 u2.out_data", 32'(od2), 32'(texp[i]));
      chk("w16 u2.out_valid", 32'(vld2), 1);
    end
    drive(1, 16'h8001, 1, 0, 1);
    chk("w16 toggle u2.out_data", 32'(od2), 0);

    // randomized traffic: first with occasional clears, then none
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
            (i < 1500) && ($urandom_range(0, 63) == 0),
            $urandom_range(0, 3) != 0);
    end
    drive(0, 0, 0, 0, 1);
    chk("rand u0.sat reached", 32'(sat0), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
